// File: rtl/perm_bits_inv_seq.sv
// Word-serial bit-permutation unit for the 64-bit LDMAC state (four 16-bit words).
// Buffers one permuted 4-word block, then streams it out in word order.
module perm_bits_inv_seq #(
    parameter int ALLOW_FWD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    // state | meaning
    // LOAD  | accepting words w0..w3 into the buffer
    // DRAIN | streaming buffered words out, no input accepted
    localparam logic LOAD  = 1'b0;
    localparam logic DRAIN = 1'b1;

    logic        state_q, state_d;
    logic [1:0]  in_cnt_q, in_cnt_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic        inv_q, inv_d;
    logic        busy_q, busy_d;
    logic [15:0] buf_q [4];

    logic        in_fire;
    logic        out_fire;
    logic        inv_sel;
    logic        inv_eff;
    logic [15:0] perm_word;

    // Forward: bit i = 4q + r of word j moves to q + 4*((j - r) mod 4).
    function automatic logic [15:0] perm_fwd(input logic [15:0] a, input logic [1:0] j);
        logic [15:0] b;
        logic [3:0]  ii;
        logic [3:0]  dst;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            ii     = 4'(i);
            dst    = {j - ii[1:0], ii[3:2]};
            b[dst] = a[i];
        end
        return b;
    endfunction

    // Inverse: output bit k of word j takes input bit 4*(k%4) + ((j - k/4) mod 4).
    function automatic logic [15:0] perm_inv(input logic [15:0] b, input logic [1:0] j);
        logic [15:0] a;
        logic [3:0]  kk;
        logic [3:0]  src;
        a = '0;
        for (int k = 0; k < 16; k++) begin
            kk     = 4'(k);
            src    = {kk[1:0], j - kk[3:2]};
            a[src] = b[k];
        end
        return a;
    endfunction

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // w0 must be permuted with the direction being sampled now, not the stale inv_q.
    assign inv_sel   = (ALLOW_FWD != 0) ? in_inv : 1'b1;
    assign inv_eff   = (in_cnt_q == 2'd0) ? inv_sel : inv_q;
    assign perm_word = inv_eff ? perm_inv(in_data, in_cnt_q) : perm_fwd(in_data, in_cnt_q);

    assign out_data  = out_valid ? buf_q[out_cnt_q] : 16'h0000;
    assign out_idx   = out_valid ? out_cnt_q : 2'd0;
    assign out_last  = out_valid & (out_cnt_q == 2'd3);
    assign busy      = busy_q;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        inv_d     = inv_q;
        busy_d    = busy_q;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt_q + 2'd1;
                    if (in_cnt_q == 2'd0) begin
                        inv_d  = inv_sel;
                        busy_d = 1'b1;
                    end
                    if (in_cnt_q == 2'd3) begin
                        out_cnt_d = 2'd0;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        state_d = LOAD;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            in_cnt_q  <= 2'd0;
            out_cnt_q <= 2'd0;
            inv_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            inv_q     <= inv_d;
            busy_q    <= busy_d;
        end
    end

    // Buffer contents are don't-care after reset; out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[in_cnt_q] <= perm_word;
        end
    end

endmodule

// File: tb/tb_perm_bits_inv_seq.sv
// Directed bench for perm_bits_inv_seq: hand-computed vectors, round trips,
// backpressure, input gaps, direction sampling and mid-block reset.
module tb_perm_bits_inv_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_inv;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_checks;
    int n_fail;

    perm_bits_inv_seq #(.ALLOW_FWD(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic push_word(input logic [15:0] d, input logic inv);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_block(input logic [63:0] blk, input logic inv, input int gap);
        for (int j = 0; j < 4; j++) begin
            push_word(blk[16*j +: 16], inv);
            if (j < 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic collect_block(output logic [63:0] res);
        int n;
        res = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) check_eq("out_valid_timeout", 64'(out_valid), 64'd1);
            check_eq("out_idx", 64'(out_idx), 64'(j));
            check_eq("out_last", 64'(out_last), 64'(j == 3));
            res[16*j +: 16] = out_data;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    logic [63:0] res;
    logic [63:0] fw;
    logic [63:0] orig;
    logic [63:0] exp_bp;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_inv    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_idx", 64'(out_idx), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Inverse single bit in word 0
        push_word(16'h1000, 1'b1);
        check_eq("busy_after_w0", 64'(busy), 64'd1);
        push_word(16'h0000, 1'b1);
        push_word(16'h0000, 1'b1);
        push_word(16'h0000, 1'b1);
        collect_block(res);
        check_eq("inv_single_bit", res, 64'h0000_0000_0000_0002);
        check_eq("busy_after_drain", 64'(busy), 64'd0);

        // Inverse per-word vectors
        push_block({16'h0001, 16'h8000, 16'h0010, 16'h0001}, 1'b1, 0);
        collect_block(res);
        check_eq("inv_per_word", res, {16'h0008, 16'h8000, 16'h0001, 16'h0001});

        // Forward, then back through inverse
        orig = {16'h0008, 16'h0004, 16'h0001, 16'h0002};
        push_block(orig, 1'b0, 0);
        collect_block(fw);
        check_eq("fwd_vector", fw, {16'h0001, 16'h0001, 16'h0010, 16'h1000});
        push_block(fw, 1'b1, 0);
        collect_block(res);
        check_eq("fwd_inv_roundtrip", res, orig);

        // All-ones is invariant in both directions
        push_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        collect_block(fw);
        check_eq("ones_fwd", fw, 64'hFFFF_FFFF_FFFF_FFFF);
        push_block(fw, 1'b1, 0);
        collect_block(res);
        check_eq("ones_inv", res, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int b = 0; b < 1000; b++) begin
            orig = {$urandom, $urandom};
            push_block(orig, 1'b0, 0);
            collect_block(fw);
            push_block(fw, 1'b1, 0);
            collect_block(res);
            check_eq("rand_roundtrip", res, orig);
        end

        // Backpressure at idx 1
        exp_bp = {16'h0008, 16'h8000, 16'h0001, 16'h0001};
        push_block({16'h0001, 16'h8000, 16'h0010, 16'h0001}, 1'b1, 0);
        out_ready = 1'b1;
        check_eq("bp_idx0", 64'(out_idx), 64'd0);
        check_eq("bp_data0", 64'(out_data), 64'(exp_bp[15:0]));
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
            check_eq("bp_hold_idx", 64'(out_idx), 64'd1);
            check_eq("bp_hold_data", 64'(out_data), 64'(exp_bp[31:16]));
            check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_idx", 64'(out_idx), 64'(j));
            check_eq("bp_data", 64'(out_data), 64'(exp_bp[16*j +: 16]));
            check_eq("bp_in_ready_drain", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("bp_in_ready_after", 64'(in_ready), 64'd1);
        check_eq("bp_out_valid_after", 64'(out_valid), 64'd0);
        check_eq("bp_out_data_after", 64'(out_data), 64'd0);

        // Gaps with in_inv toggled after w0: forward direction sticks
        push_word(16'h0002, 1'b0);
        repeat (2) @(negedge clk);
        push_word(16'h0001, 1'b1);
        repeat (2) @(negedge clk);
        push_word(16'h0004, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("gap_no_valid_before_w3", 64'(out_valid), 64'd0);
        push_word(16'h0008, 1'b1);
        check_eq("gap_valid_after_w3", 64'(out_valid), 64'd1);
        collect_block(res);
        check_eq("gap_toggle_dir", res, {16'h0001, 16'h0001, 16'h0010, 16'h1000});

        // Reset after two input words
        push_word(16'hFFFF, 1'b0);
        push_word(16'hFFFF, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        push_block({16'h0000, 16'h0000, 16'h0000, 16'h1000}, 1'b1, 0);
        collect_block(res);
        check_eq("rst_mid_clean_block", res, 64'h0000_0000_0000_0002);

        // Reset during drain at idx 2
        push_block({16'h0001, 16'h8000, 16'h0010, 16'h0001}, 1'b1, 0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check_eq("rst_drain_idx2", 64'(out_idx), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_drain_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_drain_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_drain_out_data", 64'(out_data), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_drain_nothing_emitted", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perm_bits_inv_seq.md
Name: perm_bits_inv_seq

Overview:
- Word-serial bit-permutation unit for the 64-bit LDMAC state, held as four 16-bit words w0..w3.
- Default mode applies the inverse of the state bit permutation (PermBits); a forward mode is also provided for cross-checking.
- Accepts one word per beat over a valid/ready stream and buffers a full 4-word block.
- Each word is permuted with its word-index-specific mapping, then the block is streamed out serially in word order.

Parameters:
- ALLOW_FWD, 1, when 1 in_inv selects direction; when 0 in_inv is ignored and the unit always applies the inverse.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  unit accepts an input word this cycle.
- in_data  in  16  input word; words arrive in order w0, w1, w2, w3.
- in_inv  in  1  1 = inverse permutation, 0 = forward; sampled only on the w0 handshake.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  16  permuted word.
- out_idx  out  2  index j of the word on out_data.
- out_last  out  1  high with out_valid when out_idx == 3.
- busy  out  1  high from the w0 handshake until the w3 output handshake.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Word and bit indexing: word j in 0..3; bit index within a word is i = 4q + r, with q = i/4 and r = i%4.
- Forward mapping, word j: b_j[q + 4*((j - r) mod 4)] = a_j[4q + r].
- Inverse mapping, word j: for output bit k, a_j[4*(k%4) + ((j - k/4) mod 4)] = b_j[k].
- The mapping is applied within a word only; words never mix. The unit consumes b_j and produces a_j in inverse mode.
- Permutation is applied on input acceptance. Buffer entry j stores perm_j(in_data), so the buffer holds permuted words.
- FSM states: LOAD and DRAIN. Counters: in_cnt[1:0] and out_cnt[1:0]. Direction register: inv_q.
- LOAD:
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready: store entry in_cnt and increment in_cnt.
  - If in_cnt == 0, also latch inv_q = in_inv, or 1 when ALLOW_FWD == 0.
  - The permutation applied to the word accepted with in_cnt == 0 uses the newly sampled direction, not the old inv_q.
  - When the word with in_cnt == 3 is accepted: in_cnt wraps to 0, out_cnt = 0, go to DRAIN.
- DRAIN:
  - in_ready = 0 and out_valid = 1.
  - out_data = entry[out_cnt] and out_idx = out_cnt.
  - On out_ready: increment out_cnt. If out_cnt == 3, wrap to 0 and return to LOAD.
- Latency:
  - Accepting w3 at cycle N gives out_valid = 1 with w0 at cycle N+1.
  - With out_ready held high, the block drains in 4 cycles (N+1..N+4).
  - LOAD is re-entered at N+5, so steady-state throughput is 1 block per 8 cycles.
- Gaps: in_valid low in LOAD holds state. out_ready low in DRAIN holds out_data, out_idx and out_last stable; no word is dropped or repeated.
- No overlap: a new block is not accepted in the same cycle as the last output handshake. in_ready rises the following cycle.
- in_inv is ignored except on the w0 handshake. Changing it mid-block has no effect.
- Output stability: out_data must not glitch or change while out_valid = 1 and out_ready = 0.
- Reset values: state = LOAD, in_cnt = 0, out_cnt = 0, inv_q = 1. Outputs: in_ready = 1, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0.
- Buffer contents are don't-care after reset, but out_data must read 0 while out_valid = 0.
- Reset mid-block (LOAD with in_cnt != 0, or during DRAIN): the partial or remaining block is discarded, nothing further is emitted, and the next accepted word is treated as w0.
- busy is registered. It goes high the cycle after the w0 handshake and low the cycle after the w3 output handshake.

Test Plan:
- Inverse single-bit, word 0: inv=1, block {0x1000,0,0,0} -> outputs {0x0002, 0x0000, 0x0000, 0x0000}; out_last only with idx 3.
- Inverse per-word vectors, block {0x0001, 0x0010, 0x8000, 0x0001} -> {0x0001, 0x0001, 0x8000, 0x0008}.
- Round trip:
  - Forward block {0x0002, 0x0001, 0x0004, 0x0008} -> {0x1000, 0x0010, 0x0001, 0x0001}.
  - Feeding that result back with inv=1 -> the original block.
  - 1000 random blocks must round-trip identically, including all-ones -> all-ones.
- Backpressure:
  - Hold out_ready=0 for 5 cycles at idx 1: out_data, out_idx and out_valid stay stable, and in_ready=0 throughout.
  - Then release: all 4 words are delivered exactly once, and in_ready rises the cycle after the idx 3 handshake.
- Input gaps and in_inv toggling:
  - Insert 2-cycle in_valid gaps between words and toggle in_inv after w0: result follows the direction sampled at w0.
  - out_valid rises exactly 1 cycle after the w3 handshake.
- Reset mid-operation:
  - Assert rst after 2 input words; then send a clean block: only the clean block is emitted, correctly indexed.
  - Assert rst during DRAIN at idx 2: out_valid=0 the next cycle and in_ready=1.
